// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with the IF/ID pipeline register. Owns the PC,
//   issues single-outstanding requests to instruction memory, holds one
//   response while decode is stalled, and applies redirects from control_unit.
//   In-flight fetches made stale by a redirect are killed.
//
//   Handshakes:
//     imem_req/imem_addr : a request is accepted in the cycle imem_req is high.
//                          There is no ready signal. At most one request is
//                          outstanding at a time.
//     imem_rvalid/rdata  : one response per request, at least one cycle after
//                          it. rvalid is only looked at in WAIT.
//     stallD             : level signal from decode. While high, the IF/ID
//                          register holds its contents.
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     PCsrc             00/11 next, 01 branch (PCTargetD), 10 jalr (ALUResult)
//     PCTargetD         branch/jal target
//     ALUResult         jalr target; bit 0 is cleared here
//     stallD            decode stall; IF/ID holds
//     imem_req          fetch request
//     imem_addr         fetch address (= PC)
//     imem_rvalid       fetch response valid
//     imem_rdata        fetch response data
//     instrD            IF/ID instruction (NOP_INSTR when bubble)
//     PCD, PCPlus4D     PC of instrD and PC+4
//     validD            instrD is a real instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            PCsrc,
  input  logic [DATA_WIDTH-1:0] PCTargetD,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic                  stallD,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  validD
);

  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] pc, pc_n;
  logic [DATA_WIDTH-1:0] req_pc, req_pc_n;
  logic                  kill, kill_n;
  logic [DATA_WIDTH-1:0] buf_instr, buf_pc;

  logic                  redirect;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] req_pc_plus4;
  logic                  buf_we;
  logic                  load_mem;
  logic                  load_buf;

  // 2'b11 falls through as "next" because only 01 and 10 redirect.
  assign redirect     = (PCsrc == PC_BRANCH) || (PCsrc == PC_JALR);
  assign target       = (PCsrc == PC_JALR) ? (ALUResult & ~ONE) : PCTargetD;
  assign req_pc_plus4 = req_pc + FOUR;

  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = pc;

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    req_pc_n = req_pc;
    kill_n   = kill;
    buf_we   = 1'b0;
    load_mem = 1'b0;
    load_buf = 1'b0;

    case (state)
      FETCH: begin
        // The request goes out this cycle regardless; a redirect only marks
        // its response for discard.
        req_pc_n = pc;
        state_n  = WAIT;
        if (redirect) begin
          pc_n   = target;
          kill_n = 1'b1;
        end
      end

      WAIT: begin
        if (redirect) begin
          pc_n = target;
          if (imem_rvalid) begin
            // The arriving response is the stale one; drop it and refetch.
            kill_n  = 1'b0;
            state_n = FETCH;
          end else begin
            kill_n = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = FETCH;
          end else if (!stallD) begin
            load_mem = 1'b1;
            pc_n     = req_pc_plus4;
            state_n  = FETCH;
          end else begin
            buf_we  = 1'b1;
            pc_n    = req_pc_plus4;
            state_n = FULL;
          end
        end
      end

      FULL: begin
        // The buffer is only meaningful in FULL, so leaving FULL on a
        // redirect is what invalidates it.
        if (redirect) begin
          pc_n    = target;
          state_n = FETCH;
        end else if (!stallD) begin
          load_buf = 1'b1;
          state_n  = FETCH;
        end
      end

      default: begin
        state_n = FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fetch state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      req_pc    <= '0;
      kill      <= 1'b0;
      buf_instr <= '0;
      buf_pc    <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      req_pc <= req_pc_n;
      kill   <= kill_n;
      if (buf_we) begin
        buf_instr <= imem_rdata;
        buf_pc    <= req_pc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register. A redirect bubbles it even while decode is stalled.
  // A bubble keeps PCD/PCPlus4D so they still name the last real instruction.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      validD   <= 1'b0;
    end else if (redirect) begin
      instrD <= NOP_INSTR;
      validD <= 1'b0;
    end else if (load_mem) begin
      instrD   <= imem_rdata;
      PCD      <= req_pc;
      PCPlus4D <= req_pc_plus4;
      validD   <= 1'b1;
    end else if (load_buf) begin
      instrD   <= buf_instr;
      PCD      <= buf_pc;
      PCPlus4D <= buf_pc + FOUR;
      validD   <= 1'b1;
    end else if (!stallD) begin
      instrD <= NOP_INSTR;
      validD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A memory model answers each request after
//   a programmable latency. Every instruction expected on the IF/ID register is
//   pushed into exp_q, and a monitor pops and compares each newly loaded one.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [1:0]  PCsrc;
  logic [31:0] PCTargetD;
  logic [31:0] ALUResult;
  logic        stallD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        validD;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .PCsrc       (PCsrc),
    .PCTargetD   (PCTargetD),
    .ALUResult   (ALUResult),
    .stallD      (stallD),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instrD      (instrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .validD      (validD)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset / cycle counter
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Counters and scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];   // {instr, pc}
  int last_pop_cyc = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h0050_0093;
      32'hBFC0_0004: return 32'h00A0_0113;
      default:       return ~a;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_q.push_back({mem_word(a), a});
  endtask

  // Waits for the next request (bounded), checks its address, returns its cycle.
  task automatic wait_req(input string name, input logic [31:0] exp_addr, output int c);
    int n;
    n = 0;
    c = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!imem_req && n < 30);
    if (!imem_req) begin
      checks++;
      errors++;
      $display("FAIL %s: no imem_req within 30 cycles, required addr %h", name, exp_addr);
    end else begin
      check(name, imem_addr, exp_addr);
      c = cyc;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d instructions never appeared, required 0", name, exp_q.size());
    end
  endtask

  // Monitor: IF/ID takes a new instruction only at an edge where stallD was 0.
  initial begin
    logic        stall_q;
    logic [63:0] e;
    logic [31:0] p4;
    stall_q = 1'b1;
    forever begin
      @(posedge clk);
      stall_q = stallD;
      @(negedge clk);
      if (validD && !stall_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got instr %h pc %h, required no instruction", instrD, PCD);
        end else begin
          e  = exp_q.pop_front();
          p4 = e[31:0] + 32'd4;
          check("sb_instr", instrD, e[63:32]);
          check("sb_pcd", PCD, e[31:0]);
          check("sb_pcplus4", PCPlus4D, p4);
        end
        last_pop_cyc = cyc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory model: single outstanding, response lat cycles after the request.
  // It ignores rst, so a request abandoned by reset still gets its response.
  // ---------------------------------------------------------------------------
  int          lat = 1;
  logic        pend;
  int          cnt;
  logic [31:0] pend_addr;

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    pend        = 1'b0;
    cnt         = 0;
    pend_addr   = '0;
    forever begin
      @(negedge clk);
      if (imem_req && !pend) begin
        pend      = 1'b1;
        cnt       = lat;
        pend_addr = imem_addr;
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"},   imem_addr, 32'hBFC0_0000);
    check({tag, "_instr"},  instrD, NOP);
    check({tag, "_pcd"},    PCD, 32'd0);
    check({tag, "_pcp4"},   PCPlus4D, 32'd0);
    check({tag, "_valid"},  {31'd0, validD}, 32'd0);
  endtask

  initial begin
    int rel, r0, r1, r2, q, w, j, f, k, c;

    rst       = 1'b1;
    PCsrc     = 2'b00;
    PCTargetD = '0;
    ALUResult = '0;
    stallD    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Reset release, L=1: two instructions, requests every 2 cycles
    push_exp(32'hBFC0_0000);
    push_exp(32'hBFC0_0004);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel = cyc;
    wait_req("first_req", 32'hBFC0_0000, r0);
    check("first_req_cycle", r0, rel);
    wait_req("second_req", 32'hBFC0_0004, r1);
    check("req_spacing", r1 - r0, 32'd2);

    // Stall for 3 cycles while the response to BFC00008 returns; PCsrc=11
    // during the stall must act as plain "next".
    wait_req("third_req", 32'hBFC0_0008, r2);
    stallD    = 1'b1;
    PCsrc     = 2'b11;
    PCTargetD = 32'h1234_5678;
    ALUResult = 32'h8765_4321;
    @(negedge clk);
    check("instr_one_cycle_after_rvalid", last_pop_cyc, r1 + 2);
    check("stall_wait_no_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("stall_hold_instr", instrD, 32'h00A0_0113);
    check("stall_hold_pcd", PCD, 32'hBFC0_0004);
    check("stall_hold_valid", {31'd0, validD}, 32'd1);
    check("full_no_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    stallD    = 1'b0;
    PCsrc     = 2'b00;
    PCTargetD = '0;
    ALUResult = '0;
    lat       = 3;
    push_exp(32'hBFC0_0008);
    wait_req("fetch_after_full", 32'hBFC0_000C, q);
    check("fetch_after_full_cycle", q, r2 + 4);

    // Branch issued in WAIT with L=3
    @(posedge clk);
    #1;
    PCsrc     = 2'b01;
    PCTargetD = 32'hBFC0_0040;
    @(posedge clk);
    #1;
    PCsrc     = 2'b00;
    PCTargetD = '0;
    @(negedge clk);
    check("branch_bubble_instr", instrD, NOP);
    check("branch_bubble_valid", {31'd0, validD}, 32'd0);
    @(negedge clk);
    check("branch_wait_kill_no_req", {31'd0, imem_req}, 32'd0);
    wait_req("branch_target", 32'hBFC0_0040, w);
    check("branch_target_cycle", w, q + 4);
    check("killed_not_loaded", {31'd0, validD}, 32'd0);

    // JALR coincident with the response to BFC00040 (WAIT + rvalid)
    @(posedge clk);
    #1;
    lat = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    PCsrc     = 2'b10;
    ALUResult = 32'hBFC0_0101;
    @(posedge clk);
    #1;
    PCsrc     = 2'b00;
    ALUResult = '0;
    wait_req("jalr_target", 32'hBFC0_0100, j);
    check("jalr_target_cycle", j, w + 4);
    check("jalr_discard_valid", {31'd0, validD}, 32'd0);

    // Redirect in FULL with stallD=1; target FFFFFFFC also exercises wraparound
    stallD = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("parked_full_no_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    f         = cyc;
    PCsrc     = 2'b01;
    PCTargetD = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    PCsrc     = 2'b00;
    PCTargetD = '0;
    stallD    = 1'b0;
    lat       = 3;
    push_exp(32'hFFFF_FFFC);
    @(negedge clk);
    check("full_redirect_bubble_instr", instrD, NOP);
    check("full_redirect_bubble_valid", {31'd0, validD}, 32'd0);
    check("full_redirect_req", {31'd0, imem_req}, 32'd1);
    check("full_redirect_addr", imem_addr, 32'hFFFF_FFFC);
    wait_req("wrap_addr", 32'h0000_0000, k);
    check("wrap_req_cycle", k, f + 5);

    // Reset pulsed while in WAIT; the abandoned response arrives in FETCH
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp(32'hBFC0_0000);
    @(negedge clk);
    check("post_reset_req", {31'd0, imem_req}, 32'd1);
    check("post_reset_addr", imem_addr, 32'hBFC0_0000);
    check("stray_rvalid_ignored", {31'd0, validD}, 32'd0);
    wait_drain("post_reset_drain");
    #1;
    stallD = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("final_next_req_addr_hold", imem_addr, 32'hBFC0_0008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
